// File: rtl/gpio_fifo_drain.sv
// gpio_fifo_drain: pops words from the GPIO HSM FIFO and presents each one to the HSM
// over a four-phase req/ack handshake, with a completed-byte count and a sticky timeout flag.
module gpio_fifo_drain #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned SETUP_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read,
   output logic [DATA_WIDTH-1:0] gpio_data,
   output logic                  gpio_req,
   input  logic                  gpio_ack,
   output logic                  busy,
   output logic                  timeout_err,
   output logic [15:0]           sent_count
);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LATCH,
      SETUP,
      REQ_HI,
      REQ_LO
   } state_t;

   localparam logic [7:0]  SETUP_LOAD = 8'(SETUP_CYCLES);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic        ack_meta;
   logic        ack_s;
   logic [7:0]  setup_cnt;
   logic [15:0] tmo_cnt;
   logic        tmo_hit;
   logic        setup_done;

   assign tmo_hit    = (tmo_cnt == TMO_LAST);
   assign setup_done = (setup_cnt == 8'd1);
   assign busy       = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable && !fifo_empty && !ack_s) state_next = POP;
         POP:     state_next = LATCH;
         LATCH:   state_next = SETUP;
         SETUP:   if (setup_done) state_next = REQ_HI;
         REQ_HI: begin
            if (ack_s)        state_next = REQ_LO;
            else if (tmo_hit) state_next = IDLE;
         end
         REQ_LO: begin
            if (!ack_s || tmo_hit) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // fifo_read is registered from the next state so the strobe is high exactly while in POP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ack_meta    <= 1'b0;
         ack_s       <= 1'b0;
         fifo_read   <= 1'b0;
         gpio_data   <= '0;
         gpio_req    <= 1'b0;
         timeout_err <= 1'b0;
         sent_count  <= '0;
         setup_cnt   <= '0;
         tmo_cnt     <= '0;
      end else begin
         state     <= state_next;
         ack_meta  <= gpio_ack;
         ack_s     <= ack_meta;
         fifo_read <= (state_next == POP);
         case (state)
            LATCH: begin
               gpio_data <= fifo_data;
               setup_cnt <= SETUP_LOAD;
            end
            SETUP: begin
               setup_cnt <= setup_cnt - 8'd1;
               if (setup_done) begin
                  gpio_req <= 1'b1;
                  tmo_cnt  <= '0;
               end
            end
            REQ_HI: begin
               if (ack_s) begin
                  gpio_req   <= 1'b0;
                  sent_count <= sent_count + 16'd1;
                  tmo_cnt    <= '0;
               end else if (tmo_hit) begin
                  timeout_err <= 1'b1;
                  gpio_req    <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            REQ_LO: begin
               if (ack_s) begin
                  if (tmo_hit) begin
                     timeout_err <= 1'b1;
                     gpio_req    <= 1'b0;
                  end else begin
                     tmo_cnt <= tmo_cnt + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_fifo_drain.sv
// Directed bench for gpio_fifo_drain: FIFO and HSM models around the DUT, one task per scenario.
module tb_gpio_fifo_drain;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        fifo_empty;
   logic [7:0]  fifo_data = 8'h00;
   logic        fifo_read;
   logic [7:0]  gpio_data;
   logic        gpio_req;
   logic        gpio_ack = 1'b0;
   logic        busy;
   logic        timeout_err;
   logic [15:0] sent_count;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   gpio_fifo_drain #(
      .DATA_WIDTH    (8),
      .SETUP_CYCLES  (2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .gpio_data  (gpio_data),
      .gpio_req   (gpio_req),
      .gpio_ack   (gpio_ack),
      .busy       (busy),
      .timeout_err(timeout_err),
      .sent_count (sent_count)
   );

   // FIFO model: registered output, valid the clock after read is sampled.
   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_read && !fifo_empty) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 8'd1;
      end
   end

   // HSM model: ack follows req one clock later.
   bit hsm_on = 1'b1;
   bit ack_stuck = 1'b0;
   always @(posedge clk) gpio_ack <= ack_stuck | (hsm_on & gpio_req);

   // Monitor sampling pre-edge values.
   int unsigned cyc = 0;
   int unsigned n_reads = 0;
   int unsigned n_bad_reads = 0;
   int unsigned n_req = 0;
   int unsigned n_unstable = 0;
   int unsigned chg_cyc = 0;
   int unsigned read_cyc = 0;
   int unsigned rise_cyc = 0;
   logic [7:0]  data_prev = 8'h00;
   logic        req_prev = 1'b0;
   logic [7:0]  presented [0:63];

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      data_prev <= gpio_data;
      req_prev  <= gpio_req;
      if (gpio_data != data_prev) chg_cyc <= cyc;
      if (fifo_read) begin
         n_reads  <= n_reads + 1;
         read_cyc <= cyc;
         if (fifo_empty) n_bad_reads <= n_bad_reads + 1;
      end
      if (gpio_req && !req_prev) begin
         presented[n_req[5:0]] <= gpio_data;
         n_req    <= n_req + 1;
         rise_cyc <= cyc;
      end
      if (gpio_req && gpio_data != data_prev) n_unstable <= n_unstable + 1;
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      ack_stuck = 1'b0;
      hsm_on = 1'b1;
      @(negedge clk);
      wr_ptr = rd_ptr;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_quiet(input int unsigned budget, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && fifo_empty && !gpio_ack && !gpio_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int unsigned r0;
      reset = 1'b1;
      enable = 1'b1;
      ack_stuck = 1'b1;
      push(8'h5A);
      repeat (3) @(negedge clk);
      vectors++; if (fifo_read !== 1'b0) begin miscompares++; $display("FAIL reset_fifo_read: got %b expected 0", fifo_read); end
      vectors++; if (gpio_req !== 1'b0) begin miscompares++; $display("FAIL reset_gpio_req: got %b expected 0", gpio_req); end
      vectors++; if (gpio_data !== 8'h00) begin miscompares++; $display("FAIL reset_gpio_data: got %h expected 00", gpio_data); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      vectors++; if (sent_count !== 16'h0000) begin miscompares++; $display("FAIL reset_sent_count: got %h expected 0000", sent_count); end
      // stuck-high ack in IDLE must block pops without raising a timeout
      enable = 1'b0;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      r0 = n_reads;
      enable = 1'b1;
      repeat (40) @(negedge clk);
      vectors++; if (n_reads !== r0) begin miscompares++; $display("FAIL stuck_ack_reads: got %0d expected %0d", n_reads, r0); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stuck_ack_busy: got %b expected 0", busy); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL stuck_ack_timeout: got %b expected 0", timeout_err); end
   endtask

   task automatic test_single();
      int unsigned r0, q0;
      bit ok;
      do_reset();
      r0 = n_reads;
      q0 = n_req;
      push(8'hA5);
      enable = 1'b1;
      wait_quiet(100, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_done: got busy=%b req=%b expected idle", busy, gpio_req); end
      vectors++; if (n_reads - r0 !== 1) begin miscompares++; $display("FAIL single_reads: got %0d expected 1", n_reads - r0); end
      vectors++; if (n_req - q0 !== 1) begin miscompares++; $display("FAIL single_reqs: got %0d expected 1", n_req - q0); end
      vectors++; if (presented[6'(q0)] !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h expected a5", presented[6'(q0)]); end
      vectors++; if (rise_cyc - chg_cyc !== 2) begin miscompares++; $display("FAIL single_setup: got %0d expected 2", rise_cyc - chg_cyc); end
      vectors++; if (rise_cyc - read_cyc !== 4) begin miscompares++; $display("FAIL single_latency: got %0d expected 4", rise_cyc - read_cyc); end
      vectors++; if (sent_count !== 16'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", sent_count); end
      vectors++; if (gpio_data !== 8'hA5) begin miscompares++; $display("FAIL single_hold: got %h expected a5", gpio_data); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL single_timeout: got %b expected 0", timeout_err); end
   endtask

   task automatic test_burst();
      int unsigned r0, q0, b0;
      bit ok;
      do_reset();
      r0 = n_reads;
      q0 = n_req;
      b0 = n_bad_reads;
      for (int unsigned i = 1; i <= 16; i++) push(8'(i));
      enable = 1'b1;
      wait_quiet(16 * 20 + 50, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL burst_done: got busy=%b empty=%b expected idle", busy, fifo_empty); end
      vectors++; if (n_reads - r0 !== 16) begin miscompares++; $display("FAIL burst_reads: got %0d expected 16", n_reads - r0); end
      vectors++; if (n_req - q0 !== 16) begin miscompares++; $display("FAIL burst_reqs: got %0d expected 16", n_req - q0); end
      for (int unsigned i = 0; i < 16; i++) begin
         vectors++;
         if (presented[6'(q0 + i)] !== 8'(i + 1)) begin
            miscompares++;
            $display("FAIL burst_order[%0d]: got %h expected %h", i, presented[6'(q0 + i)], 8'(i + 1));
         end
      end
      vectors++; if (sent_count !== 16'd16) begin miscompares++; $display("FAIL burst_count: got %0d expected 16", sent_count); end
      vectors++; if (n_bad_reads !== b0) begin miscompares++; $display("FAIL burst_read_empty: got %0d expected %0d", n_bad_reads, b0); end
      vectors++; if (n_unstable !== 0) begin miscompares++; $display("FAIL burst_stable: got %0d expected 0", n_unstable); end
   endtask

   task automatic test_timeout();
      int unsigned k, q0;
      bit seen, ok;
      do_reset();
      hsm_on = 1'b0;
      push(8'h3C);
      enable = 1'b1;
      seen = 1'b0;
      for (int unsigned i = 0; i < 30; i++) begin
         @(negedge clk);
         if (gpio_req) begin seen = 1'b1; break; end
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL timeout_req_rise: got req=%b expected 1", gpio_req); end
      k = 0;
      while (k < 40 && !timeout_err) begin
         @(negedge clk);
         k++;
      end
      vectors++; if (k !== 16) begin miscompares++; $display("FAIL timeout_delay: got %0d expected 16", k); end
      vectors++; if (gpio_req !== 1'b0) begin miscompares++; $display("FAIL timeout_req_drop: got %b expected 0", gpio_req); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_idle: got busy=%b expected 0", busy); end
      vectors++; if (sent_count !== 16'd0) begin miscompares++; $display("FAIL timeout_count: got %0d expected 0", sent_count); end
      hsm_on = 1'b1;
      q0 = n_req;
      push(8'h7E);
      wait_quiet(100, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL timeout_next_done: got busy=%b expected 0", busy); end
      vectors++; if (presented[6'(q0)] !== 8'h7E) begin miscompares++; $display("FAIL timeout_next_data: got %h expected 7e", presented[6'(q0)]); end
      vectors++; if (sent_count !== 16'd1) begin miscompares++; $display("FAIL timeout_next_count: got %0d expected 1", sent_count); end
      vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
   endtask

   task automatic test_enable_drop();
      int unsigned r0, q0;
      bit seen, ok;
      do_reset();
      r0 = n_reads;
      q0 = n_req;
      push(8'h11);
      push(8'h22);
      enable = 1'b1;
      seen = 1'b0;
      for (int unsigned i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fifo_read) begin seen = 1'b1; break; end
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL enable_pop: got read=%b expected 1", fifo_read); end
      repeat (2) @(negedge clk);
      enable = 1'b0;
      repeat (40) @(negedge clk);
      vectors++; if (n_reads - r0 !== 1) begin miscompares++; $display("FAIL enable_reads: got %0d expected 1", n_reads - r0); end
      vectors++; if (sent_count !== 16'd1) begin miscompares++; $display("FAIL enable_count: got %0d expected 1", sent_count); end
      vectors++; if (presented[6'(q0)] !== 8'h11) begin miscompares++; $display("FAIL enable_data: got %h expected 11", presented[6'(q0)]); end
      vectors++; if (busy !== 1'b0 || fifo_empty !== 1'b0) begin miscompares++; $display("FAIL enable_hold: got busy=%b empty=%b expected 0 0", busy, fifo_empty); end
      enable = 1'b1;
      wait_quiet(100, ok);
      vectors++; if (!ok || sent_count !== 16'd2) begin miscompares++; $display("FAIL enable_resume: got count=%0d done=%b expected 2 1", sent_count, ok); end
      vectors++; if (presented[6'(q0 + 1)] !== 8'h22) begin miscompares++; $display("FAIL enable_resume_data: got %h expected 22", presented[6'(q0 + 1)]); end
   endtask

   task automatic test_reset_mid();
      int unsigned r0;
      bit seen;
      do_reset();
      hsm_on = 1'b0;
      r0 = n_reads;
      push(8'h44);
      enable = 1'b1;
      seen = 1'b0;
      for (int unsigned i = 0; i < 30; i++) begin
         @(negedge clk);
         if (gpio_req) begin seen = 1'b1; break; end
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL rstmid_req: got %b expected 1", gpio_req); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++; if (gpio_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_req_drop: got %b expected 0", gpio_req); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: got busy=%b expected 0", busy); end
      vectors++; if (gpio_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %h expected 00", gpio_data); end
      reset = 1'b0;
      hsm_on = 1'b1;
      repeat (30) @(negedge clk);
      vectors++; if (n_reads - r0 !== 1) begin miscompares++; $display("FAIL rstmid_reads: got %0d expected 1", n_reads - r0); end
      vectors++; if (sent_count !== 16'd0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_lost: got count=%0d err=%b expected 0 0", sent_count, timeout_err); end
   endtask

   task automatic test_wrap();
      int unsigned q0;
      bit ok;
      do_reset();
      force dut.sent_count = 16'hFFFF;
      @(negedge clk);
      release dut.sent_count;
      @(negedge clk);
      vectors++; if (sent_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload: got %h expected ffff", sent_count); end
      q0 = n_req;
      push(8'hE1);
      enable = 1'b1;
      wait_quiet(100, ok);
      vectors++; if (!ok || sent_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_zero: got %h done=%b expected 0000 1", sent_count, ok); end
      vectors++; if (presented[6'(q0)] !== 8'hE1) begin miscompares++; $display("FAIL wrap_data0: got %h expected e1", presented[6'(q0)]); end
      push(8'hE2);
      wait_quiet(100, ok);
      vectors++; if (!ok || sent_count !== 16'h0001) begin miscompares++; $display("FAIL wrap_one: got %h done=%b expected 0001 1", sent_count, ok); end
      vectors++; if (presented[6'(q0 + 1)] !== 8'hE2) begin miscompares++; $display("FAIL wrap_data1: got %h expected e2", presented[6'(q0 + 1)]); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL wrap_timeout: got %b expected 0", timeout_err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_timeout();
      test_enable_drop();
      test_reset_mid();
      test_wrap();
      vectors++; if (n_bad_reads !== 0) begin miscompares++; $display("FAIL read_while_empty: got %0d expected 0", n_bad_reads); end
      vectors++; if (n_unstable !== 0) begin miscompares++; $display("FAIL data_stable_under_req: got %0d expected 0", n_unstable); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
